trng_sample_ctrl: RTL and testbench

Sequencing controller for the entropy sampling flip-flop that captures the XOR-tree output. It times the sampling strobes and discards a warm-up run of bits. It also runs a repetition-count health test on every sampled bit, packs accepted bits into words and presents them on a valid/ready output port. It sits between the sampling flip-flop and the downstream consumer (e.g. conditioner or UART packer).

---
 rtl/trng_pkg.sv | 17 +
 rtl/trng_rep_test.sv | 42 ++++
 rtl/trng_sample_ctrl.sv | 158 +++++++++++++++
 tb/tb_trng_sample_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG sampling controller.
// Holds the controller state encoding and counter width helper.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COLLECT,
    ST_HOLD,
    ST_FAIL
  } state_t;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test on a strobed bit stream.
// fail pulses on the strobe that completes a run of REP_LIMIT equal bits.
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = 34
) (
  input  logic d_clk,
  input  logic d_rst,
  input  logic clr,
  input  logic stb,
  input  logic bit_in,
  output logic fail
);

  localparam int RW = cnt_w(REP_LIMIT);
  localparam logic [RW-1:0] LIM = RW'(REP_LIMIT);

  logic [RW-1:0] run_q;
  logic [RW-1:0] run_n;
  logic          prev_q;

  // run_q == 0 marks "no previous bit yet"
  always_comb begin
    run_n = RW'(1);
    if (run_q != '0 && bit_in == prev_q)
      run_n = (run_q == LIM) ? LIM : run_q + RW'(1);
  end

  assign fail = stb && (run_n == LIM);

  always_ff @(posedge d_clk) begin
    if (d_rst || clr) begin
      run_q  <= '0;
      prev_q <= 1'b0;
    end else if (stb) begin
      run_q  <= run_n;
      prev_q <= bit_in;
    end
  end

endmodule

// File: rtl/trng_sample_ctrl.sv
// Entropy sampling sequencer: strobe timing, warm-up discard,
// repetition health test and word packing onto a valid/ready port.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int SAMPLE_DIV = 16,
  parameter int WARMUP     = 256,
  parameter int REP_LIMIT  = 34
) (
  input  logic              d_clk,
  input  logic              d_rst,
  input  logic              en,
  input  logic              raw_bit,
  output logic              sample_stb,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              health_fail,
  output logic              busy
);

  localparam int DW = cnt_w(SAMPLE_DIV - 1);
  localparam int SW = cnt_w(WARMUP);
  localparam int BW = cnt_w(WORD_W);

  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] WU_LAST  = SW'(WARMUP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  state_t            state_q, state_n;
  logic [DW-1:0]     div_q, div_n;
  logic [SW-1:0]     samp_q, samp_n;
  logic [BW-1:0]     bits_q, bits_n;
  logic [WORD_W-1:0] shreg_q, shreg_n;
  logic [WORD_W-1:0] word_q, word_n;
  logic              valid_q, valid_n;
  logic              fail_q, fail_n;
  logic              stb_q, stb_n;
  logic              rt_fail;
  logic              run;

  trng_rep_test #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rep (
    .d_clk (d_clk),
    .d_rst (d_rst),
    .clr   (state_q == ST_IDLE),
    .stb   (stb_q),
    .bit_in(raw_bit),
    .fail  (rt_fail)
  );

  always_comb begin
    state_n = state_q;
    samp_n  = samp_q;
    bits_n  = bits_q;
    shreg_n = shreg_q;
    word_n  = word_q;
    valid_n = valid_q;
    fail_n  = fail_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_n = ST_WARMUP;
          samp_n  = '0;
          bits_n  = '0;
          shreg_n = '0;
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          state_n = ST_IDLE;
        end else if (stb_q) begin
          if (rt_fail) begin
            state_n = ST_FAIL;
            fail_n  = 1'b1;
          end else if (samp_q == WU_LAST) begin
            state_n = ST_COLLECT;
          end else begin
            samp_n = samp_q + SW'(1);
          end
        end
      end
      ST_COLLECT: begin
        if (!en) begin
          state_n = ST_IDLE;
        end else if (stb_q) begin
          if (rt_fail) begin
            state_n = ST_FAIL;
            fail_n  = 1'b1;
          end else begin
            shreg_n = {shreg_q[WORD_W-2:0], raw_bit};
            if (bits_q == BIT_LAST) begin
              word_n  = shreg_n;
              valid_n = 1'b1;
              bits_n  = '0;
              state_n = ST_HOLD;
            end else begin
              bits_n = bits_q + BW'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_n = 1'b0;
          state_n = en ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_FAIL: ;
      default: state_n = ST_IDLE;
    endcase
  end

  // divider free-runs only while staying inside WARMUP/COLLECT
  always_comb begin
    run = (state_q == ST_WARMUP || state_q == ST_COLLECT) &&
          (state_n == ST_WARMUP || state_n == ST_COLLECT);
    div_n = '0;
    if (run)
      div_n = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    stb_n = run && (div_n == DIV_LAST);
  end

  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      samp_q  <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      samp_q  <= samp_n;
      bits_q  <= bits_n;
      shreg_q <= shreg_n;
      word_q  <= word_n;
      valid_q <= valid_n;
      fail_q  <= fail_n;
      stb_q   <= stb_n;
    end
  end

  assign sample_stb  = stb_q;
  assign out_word    = word_q;
  assign out_valid   = valid_q;
  assign health_fail = fail_q;
  assign busy        = (state_q == ST_WARMUP) ||
                       (state_q == ST_COLLECT) ||
                       (state_q == ST_HOLD);

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl with a small configuration.
// Bits are fed to the DUT on each observed strobe from a queue.
module tb_trng_sample_ctrl;

  logic       d_clk = 1'b0;
  logic       d_rst;
  logic       en;
  logic       raw_bit;
  logic       sample_stb;
  logic [7:0] out_word;
  logic       out_valid;
  logic       out_ready;
  logic       health_fail;
  logic       busy;

  always #5 d_clk = ~d_clk;

  trng_sample_ctrl #(
    .WORD_W    (8),
    .SAMPLE_DIV(4),
    .WARMUP    (4),
    .REP_LIMIT (5)
  ) dut (
    .d_clk      (d_clk),
    .d_rst      (d_rst),
    .en         (en),
    .raw_bit    (raw_bit),
    .sample_stb (sample_stb),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .health_fail(health_fail),
    .busy       (busy)
  );

  typedef struct {
    logic [11:0] bits;
    logic        exp_fail;
    logic [7:0]  exp_word;
    int          exp_stb;
  } vec_t;

  vec_t vt [8];
  int   n_vec = 0;
  int   n_err = 0;
  int   stb_cnt = 0;
  logic feed_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge d_clk);
    #1;
    if (sample_stb === 1'b1) begin
      stb_cnt++;
      if (feed_q.size() > 0) raw_bit = feed_q.pop_front();
      else raw_bit = 1'b0;
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) feed_q.push_back(v[i]);
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    en    = 1'b0;
    repeat (2) tick();
    d_rst = 1'b0;
    feed_q.delete();
    stb_cnt = 0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !(out_valid || health_fail); i++) tick();
  endtask

  task automatic lat_to_stb(output int k);
    k = 0;
    while (sample_stb !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int t;
    int t5;
    int n_s;
    logic stable;

    vt[0] = '{12'h5AA, 1'b0, 8'hAA, 12};
    vt[1] = '{12'hAF0, 1'b0, 8'hF0, 12};
    vt[2] = '{12'h63C, 1'b0, 8'h3C, 12};
    vt[3] = '{12'h5F8, 1'b1, 8'h00, 8};
    vt[4] = '{12'hF80, 1'b1, 8'h00, 5};
    vt[5] = '{12'h82A, 1'b1, 8'h00, 6};
    vt[6] = '{12'h5A0, 1'b1, 8'h00, 12};
    vt[7] = '{12'h087, 1'b0, 8'h87, 12};

    // reset with en high and raw_bit toggling
    d_rst     = 1'b1;
    en        = 1'b1;
    out_ready = 1'b1;
    raw_bit   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      raw_bit = ~raw_bit;
      tick();
      chk("reset_outputs",
          {19'd0, sample_stb, out_valid, health_fail, busy, out_word},
          32'd0);
    end
    push_bits(32'h5AA, 12);
    stb_cnt = 0;
    d_rst   = 1'b0;
    k = 0;
    while (sample_stb !== 1'b1 && k < 20) begin
      tick();
      k++;
      if (k == 1) chk("busy_after_exit", busy, 1);
    end
    chk("first_stb_latency", k, 4);

    // first word AA with out_ready high
    wait_done(100);
    chk("word1_valid", out_valid, 1);
    chk("word1_value", out_word, 8'hAA);
    chk("word1_strobes", stb_cnt, 12);
    push_bits(32'hAA, 8);
    tick();
    chk("word1_valid_1cyc", out_valid, 0);
    lat_to_stb(k);
    chk("next_word_stb_lat", k + 1, 4);

    // second word held with out_ready low
    out_ready = 1'b0;
    wait_done(100);
    chk("word2_value", out_word, 8'hAA);
    n_s    = 0;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sample_stb) n_s++;
      if (out_valid !== 1'b1 || out_word !== 8'hAA) stable = 1'b0;
    end
    chk("hold_no_strobes", n_s, 0);
    chk("hold_stable", stable, 1);
    chk("hold_busy", busy, 1);
    push_bits(32'h55, 8);
    out_ready = 1'b1;
    tick();
    chk("hold_accept", out_valid, 0);
    lat_to_stb(k);
    chk("resume_stb_lat", k + 1, 4);

    // en dropped after 3 collected bits, then restart
    do_reset();
    out_ready = 1'b1;
    push_bits(32'h5AA, 12);
    en = 1'b1;
    for (int c = 0; c < 100 && stb_cnt < 7; c++) tick();
    chk("drop_stb_count", stb_cnt, 7);
    en = 1'b0;
    tick();
    chk("drop_idle", {sample_stb, out_valid, busy}, 3'b000);
    n_s = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (sample_stb) n_s++;
    end
    chk("drop_no_strobes", n_s, 0);
    feed_q.delete();
    push_bits(32'hA3C, 12);
    stb_cnt = 0;
    en = 1'b1;
    wait_done(100);
    chk("restart_word", out_word, 8'h3C);
    chk("restart_strobes", stb_cnt, 12);
    chk("restart_no_fail", health_fail, 0);

    // raw_bit stuck at 1
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) feed_q.push_back(1'b1);
    raw_bit = 1'b1;
    en = 1'b1;
    t  = 0;
    t5 = -1;
    while (health_fail !== 1'b1 && t < 100) begin
      tick();
      t++;
      if (stb_cnt == 5 && t5 < 0) t5 = t;
    end
    chk("stuck_fail", health_fail, 1);
    chk("stuck_strobes", stb_cnt, 5);
    chk("stuck_fail_lat", t - t5, 1);
    n_s = 0;
    for (int c = 0; c < 20; c++) begin
      en = ~en;
      tick();
      if (sample_stb || out_valid || busy) n_s++;
    end
    chk("fail_absorbing", n_s, 0);
    chk("fail_sticky", health_fail, 1);
    d_rst = 1'b1;
    en    = 1'b0;
    tick();
    chk("fail_cleared", health_fail, 0);
    d_rst = 1'b0;

    // table-driven words and health-test boundaries
    for (int v = 0; v < 8; v++) begin
      do_reset();
      out_ready = 1'b0;
      push_bits({20'd0, vt[v].bits}, 12);
      en = 1'b1;
      wait_done(200);
      chk($sformatf("vec%0d_fail", v), health_fail, vt[v].exp_fail);
      chk($sformatf("vec%0d_valid", v), out_valid, !vt[v].exp_fail);
      chk($sformatf("vec%0d_busy", v), busy, !vt[v].exp_fail);
      chk($sformatf("vec%0d_strobes", v), stb_cnt, vt[v].exp_stb);
      if (!vt[v].exp_fail)
        chk($sformatf("vec%0d_word", v), out_word, vt[v].exp_word);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
